// File: rtl/slide_game_ctrl_pkg.sv
// Shared definitions for the sliding-LED reaction game.
//   state_t / ST_*  : controller state encoding
//   TARGET_POS      : LED position that scores a hit
//   LAST_POS        : last LED position before wrapping
//   MAX_SCORE       : score that wins the game
//   level_of()      : difficulty level = number of set difficulty switches
//   step_period_m1(): step timer reload value for a given level
package slide_game_ctrl_pkg;

    localparam int unsigned NUM_LEDS = 7;
    localparam int unsigned POS_W    = 3;
    localparam int unsigned SCORE_W  = 4;
    localparam int unsigned MISS_W   = 2;
    localparam int unsigned TMR_W    = 32;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_FLASH = 2'd2;
    localparam state_t ST_OVER  = 2'd3;

    localparam logic [POS_W-1:0]   TARGET_POS = 3'd0;
    localparam logic [POS_W-1:0]   LAST_POS   = 3'd6;
    localparam logic [SCORE_W-1:0] MAX_SCORE  = 4'd9;

    // Popcount of the difficulty switches.
    function automatic logic [POS_W-1:0] level_of(input logic [NUM_LEDS-1:0] sw);
        logic [POS_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            n = n + POS_W'(sw[i]);
        end
        return n;
    endfunction

    // Timer reload for one step: base*(8-level) cycles, minus one for the zero cycle.
    function automatic logic [TMR_W-1:0] step_period_m1(input logic [TMR_W-1:0] base,
                                                        input logic [POS_W-1:0] lvl);
        return (base * (32'd8 - TMR_W'(lvl))) - 32'd1;
    endfunction

endpackage

// File: rtl/slide_game_ctrl_step_timer.sv
// Loadable down-counter with a one-cycle expiry strobe.
//   clk, reset     : clock, async active-low reset
//   load, load_val : restart the count; expiry occurs load_val+1 cycles later
//   expired_c      : high for the single cycle the count sits at zero
module slide_game_ctrl_step_timer #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired_c
);

    logic [W-1:0] cnt;
    logic         active;

    // Count down once per cycle; go idle after reaching zero unless reloaded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (load) begin
            cnt    <= load_val;
            active <= 1'b1;
        end else if (active) begin
            if (cnt == '0) begin
                active <= 1'b0;
            end else begin
                cnt <= cnt - W'(1);
            end
        end
    end

    assign expired_c = active && (cnt == '0);

endmodule

// File: rtl/slide_game_ctrl.sv
// Sliding-LED reaction game controller.
//   clk, reset : clock, async active-low reset
//   start      : begin/restart a game (accepted in IDLE or OVER)
//   btn_pulse  : one pulse per debounced button press
//   diff       : difficulty switches, level = popcount latched at start
//   led        : one-hot sliding LED (led[0] is the target), all-on while flashing
//   score      : hit count 0..9
//   misses     : miss count
//   game_over  : high in OVER
//   win        : high in OVER when the game ended on score 9
module slide_game_ctrl
    import slide_game_ctrl_pkg::*;
#(
    parameter int unsigned STEP_BASE    = 3000000,
    parameter int unsigned FLASH_CYCLES = 12000000,
    parameter int unsigned MAX_MISS     = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                btn_pulse,
    input  logic [NUM_LEDS-1:0] diff,
    output logic [NUM_LEDS-1:0] led,
    output logic [SCORE_W-1:0]  score,
    output logic [MISS_W-1:0]   misses,
    output logic                game_over,
    output logic                win
);

    localparam logic [TMR_W-1:0] FLASH_M1 = TMR_W'(FLASH_CYCLES) - 32'd1;

    state_t              state, state_n;
    logic [POS_W-1:0]    pos, pos_n;
    logic [POS_W-1:0]    level, level_n;
    logic [SCORE_W-1:0]  score_n;
    logic [MISS_W-1:0]   misses_n;
    logic                win_n;
    logic                game_over_n;
    logic [NUM_LEDS-1:0] led_n;

    logic                tmr_load;
    logic [TMR_W-1:0]    tmr_val;
    logic                tmr_expired_c;
    logic [TMR_W-1:0]    start_period_m1;
    logic [TMR_W-1:0]    run_period_m1;

    // One timer serves both the LED step and the hit flash; they never overlap.
    slide_game_ctrl_step_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (tmr_load),
        .load_val  (tmr_val),
        .expired_c (tmr_expired_c)
    );

    assign start_period_m1 = step_period_m1(TMR_W'(STEP_BASE), level_of(diff));
    assign run_period_m1   = step_period_m1(TMR_W'(STEP_BASE), level);

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            pos       <= TARGET_POS;
            level     <= '0;
            score     <= '0;
            misses    <= '0;
            win       <= 1'b0;
            game_over <= 1'b0;
            led       <= '0;
        end else begin
            state     <= state_n;
            pos       <= pos_n;
            level     <= level_n;
            score     <= score_n;
            misses    <= misses_n;
            win       <= win_n;
            game_over <= game_over_n;
            led       <= led_n;
        end
    end

    // Next state, next output values and timer control.
    always_comb begin
        state_n     = state;
        pos_n       = pos;
        level_n     = level;
        score_n     = score;
        misses_n    = misses;
        win_n       = win;
        game_over_n = 1'b0;
        led_n       = '0;
        tmr_load    = 1'b0;
        tmr_val     = '0;

        case (state)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_n  = ST_RUN;
                    pos_n    = TARGET_POS;
                    level_n  = level_of(diff);
                    score_n  = '0;
                    misses_n = '0;
                    win_n    = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = start_period_m1;
                end
            end
            ST_RUN: begin
                if (btn_pulse && (pos == TARGET_POS)) begin
                    // A hit wins over a coincident step: pos stays at the target.
                    score_n = score + 4'd1;
                    if (score_n == MAX_SCORE) begin
                        state_n = ST_OVER;
                        win_n   = 1'b1;
                    end else begin
                        state_n  = ST_FLASH;
                        tmr_load = 1'b1;
                        tmr_val  = FLASH_M1;
                    end
                end else begin
                    if (btn_pulse) begin
                        misses_n = misses + 2'd1;
                        if (misses_n == MISS_W'(MAX_MISS)) begin
                            state_n = ST_OVER;
                        end
                    end
                    if (tmr_expired_c) begin
                        pos_n    = (pos == LAST_POS) ? TARGET_POS : pos + 3'd1;
                        tmr_load = 1'b1;
                        tmr_val  = run_period_m1;
                    end
                end
            end
            ST_FLASH: begin
                if (tmr_expired_c) begin
                    state_n  = ST_RUN;
                    pos_n    = TARGET_POS;
                    tmr_load = 1'b1;
                    tmr_val  = run_period_m1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Outputs follow the next state so they land together with it.
        case (state_n)
            ST_RUN:   led_n = 7'd1 << pos_n;
            ST_FLASH: led_n = 7'h7F;
            default:  led_n = '0;
        endcase
        game_over_n = (state_n == ST_OVER);
    end

endmodule
